// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared types and default parameters for the frame-buffer SDRAM arbiter.
package fb_arb_pkg;
    typedef enum logic {OWNER_DISP = 1'b0, OWNER_RAST = 1'b1} owner_e;
    localparam int ADDR_W_DEF          = 25;
    localparam int DATA_W_DEF          = 16;
    localparam int MAX_OUTSTANDING_DEF = 8;
    localparam int STARVE_LIMIT_DEF    = 16;
endpackage

// File: rtl/arb_owner_fifo.sv
// arb_owner_fifo: in-order record of which master issued each read in flight.
module arb_owner_fifo
    import fb_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEF,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  owner_e        din,
    input  logic          pop,
    output owner_e        dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    owner_e mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= OWNER_DISP;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares one SDRAM controller between display scan-out (priority)
// and the rasterizer, with starvation protection and in-order response routing.
module fb_mem_arbiter
    import fb_arb_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int STARVE_LIMIT    = STARVE_LIMIT_DEF,
    localparam int BE_W = DATA_W / 8,
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1),
    localparam int SW   = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    output logic [BE_W-1:0]   s_byteenable,
    input  logic              s_waitrequest,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_readdatavalid,
    output logic [CW-1:0]     outstanding,
    output logic              err_orphan
);
    logic req0, req1, gnt_v, gnt_m1, lock_q, lock_m1_q;
    logic full, empty, accept, pop;
    logic [SW-1:0] starve_cnt;
    owner_e head;

    always_comb begin
        req0   = m0_read;
        req1   = m1_read | m1_write;
        gnt_v  = lock_q | req0 | req1;
        gnt_m1 = lock_q ? lock_m1_q : (req0 && starve_cnt < SW'(STARVE_LIMIT)) ? 1'b0 : req1;
        // A read blocked by a full owner FIFO is never presented, so it cannot form a lock.
        s_read         = reset_n & gnt_v & (gnt_m1 ? m1_read : m0_read) & ~full;
        s_write        = reset_n & gnt_v & gnt_m1 & m1_write;
        s_address      = gnt_m1 ? m1_address : m0_address;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m0_waitrequest = ~(gnt_v & ~gnt_m1) | s_waitrequest | full;
        m1_waitrequest = ~(gnt_v & gnt_m1) | s_waitrequest | (m1_read & full);
        accept         = (s_read | s_write) & ~s_waitrequest;
        pop            = s_readdatavalid & ~empty;
        m0_readdata      = s_readdata;
        m1_readdata      = s_readdata;
        m0_readdatavalid = pop & (head == OWNER_DISP);
        m1_readdatavalid = pop & (head == OWNER_RAST);
    end

    arb_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept & s_read),
        .din     (gnt_m1 ? OWNER_RAST : OWNER_DISP),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (outstanding)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q     <= 1'b0;
            lock_m1_q  <= 1'b0;
            starve_cnt <= '0;
            err_orphan <= 1'b0;
        end else begin
            lock_q    <= (s_read | s_write) & s_waitrequest;
            lock_m1_q <= gnt_m1;
            if (!req1 || (accept && gnt_m1)) starve_cnt <= '0;
            else if (accept && starve_cnt < SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
            if (s_readdatavalid && empty) err_orphan <= 1'b1;
        end
    end
endmodule
